// File: rtl/stage_fifo.sv
// -----------------------------------------------------------------------------
// stage_fifo
//   Parametrised valid/ready buffer placed between pipeline stages. It holds up
//   to DEPTH payloads of WIDTH bits, so an upstream stage can keep issuing while
//   the downstream stage stalls. A synchronous flush discards every held entry
//   when the pipeline is redirected (branch, ecall, mret).
//
// Parameters
//   WIDTH  payload width in bits (>= 1)
//   DEPTH  number of entries (>= 1, need not be a power of two)
//   CW     width of count, derived as $clog2(DEPTH+1)
//
// Ports
//   clk      in   clock, all state changes on the rising edge
//   rst      in   asynchronous active-high reset
//   flush    in   synchronous clear of all held entries
//   s_valid  in   upstream offers s_data
//   s_ready  out  buffer can accept this cycle (registered state only)
//   s_data   in   upstream payload
//   m_valid  out  head entry is valid
//   m_ready  in   downstream consumes the head this cycle
//   m_data   out  head payload, all-zero when m_valid is low
//   count    out  number of occupied entries, 0..DEPTH
//
// Build option
//   STAGE_FIFO_BYPASS_EN  when defined, a payload offered to an empty buffer
//                         while downstream is ready passes straight through in
//                         the same cycle without touching storage.
// -----------------------------------------------------------------------------
module stage_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic live;       // neither reset nor flush is active
    logic not_empty;
    logic push;
    logic pop;
    logic bypass;
    logic push_store; // push that actually writes storage
    logic pop_store;  // pop that actually retires a stored entry

    assign live      = ~rst & ~flush;
    assign not_empty = (count_q != '0);

    // s_ready looks only at registered occupancy, never at m_ready.
    assign s_ready = live & (count_q != CW'(DEPTH));

`ifdef STAGE_FIFO_BYPASS_EN
    // Empty buffer with both sides ready: hand the payload straight across.
    assign bypass  = live & ~not_empty & s_valid & m_ready;
    assign m_valid = (live & not_empty) | bypass;
    assign m_data  = bypass  ? s_data          :
                     m_valid ? mem[rd_ptr_q]   : '0;
`else
    assign bypass  = 1'b0;
    assign m_valid = live & not_empty;
    assign m_data  = m_valid ? mem[rd_ptr_q] : '0;
`endif

    assign push = s_valid & s_ready;
    assign pop  = m_valid & m_ready;

    // A bypassed transfer is both a push and a pop but leaves storage alone.
    assign push_store = push & ~bypass;
    assign pop_store  = pop  & ~bypass;

    assign count = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_store) begin
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop_store) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({push_store, pop_store})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_store) begin
            mem[wr_ptr_q] <= s_data;
        end
    end

endmodule

// File: tb/tb_stage_fifo.sv
module tb_stage_fifo;

    logic clk = 1'b0;
    logic rst;

    // DEPTH=4 instance
    logic        a_flush, a_s_valid, a_s_ready, a_m_valid, a_m_ready;
    logic [31:0] a_s_data, a_m_data;
    logic [2:0]  a_count;

    // DEPTH=3 instance (non-power-of-two wrap)
    logic        b_flush, b_s_valid, b_s_ready, b_m_valid, b_m_ready;
    logic [31:0] b_s_data, b_m_data;
    logic [1:0]  b_count;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    stage_fifo #(.WIDTH(32), .DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
        .count(a_count)
    );

    stage_fifo #(.WIDTH(32), .DEPTH(3)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .count(b_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] expq[$];
    int unsigned offer;
    int unsigned outs;
    int unsigned guard;

    initial begin
        rst = 1'b1;
        a_flush = 1'b0; a_s_valid = 1'b1; a_s_data = 32'h0; a_m_ready = 1'b0;
        b_flush = 1'b0; b_s_valid = 1'b0; b_s_data = 32'h0; b_m_ready = 1'b0;

        // ---- reset held 3 cycles ----
        @(negedge clk);
        chk("rst_s_ready", a_s_ready, 0);
        chk("rst_m_valid", a_m_valid, 0);
        chk("rst_m_data",  a_m_data,  0);
        chk("rst_count",   a_count,   0);
        repeat (3) cyc();
        rst = 1'b0;
        a_s_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", a_s_ready, 1);
        chk("post_rst_count",   a_count,   0);

        // ---- basic push then pop ----
        cyc();
        a_s_valid = 1'b1; a_s_data = 32'hA5A5_0001; a_m_ready = 1'b0;
        @(negedge clk);
        chk("basic_mv_before", a_m_valid, 0);
        cyc();
        a_s_valid = 1'b0; a_m_ready = 1'b1;
        @(negedge clk);
        chk("basic_count1", a_count,   1);
        chk("basic_mv",     a_m_valid, 1);
        chk("basic_md",     a_m_data,  32'hA5A5_0001);
        cyc();
        a_m_ready = 1'b0;
        @(negedge clk);
        chk("basic_count0", a_count,   0);
        chk("basic_mv0",    a_m_valid, 0);
        chk("basic_md0",    a_m_data,  0);

        // ---- fill and stall ----
        for (int i = 0; i < 4; i++) begin
            cyc();
            a_s_valid = 1'b1; a_s_data = 32'h10 + i;
            @(negedge clk);
            chk("fill_s_ready", a_s_ready, 1);
        end
        cyc();
        a_s_data = 32'h14;
        @(negedge clk);
        chk("full_count",   a_count,   4);
        chk("full_s_ready", a_s_ready, 0);
        chk("full_md",      a_m_data,  32'h10);
        cyc();
        @(negedge clk);
        chk("stall_count", a_count,   4);
        chk("stall_mv",    a_m_valid, 1);
        chk("stall_md",    a_m_data,  32'h10);

        // ---- drain while pushing 0x20..0x27, pointers wrap ----
        cyc();
        expq = {32'h10, 32'h11, 32'h12, 32'h13};
        offer = 0; outs = 0; guard = 0;
        a_m_ready = 1'b1; a_s_valid = 1'b1; a_s_data = 32'h20;
        while (outs < 12 && guard < 40) begin
            @(negedge clk);
            if (a_s_valid && a_s_ready) begin
                expq.push_back(a_s_data);
                offer++;
            end
            if (a_m_valid) begin
                chk("drain_has_exp", expq.size() > 0, 1);
                if (expq.size() > 0) chk("drain_data", a_m_data, expq.pop_front());
                outs++;
            end
            cyc();
            a_s_valid = (offer < 8);
            a_s_data  = 32'h20 + offer;
            guard++;
        end
        chk("drain_outs",   outs, 12);
        chk("drain_offers", offer, 8);
        a_s_valid = 1'b0; a_m_ready = 1'b0;
        @(negedge clk);
        chk("drain_count0", a_count,   0);
        chk("drain_mv0",    a_m_valid, 0);

        // ---- simultaneous push/pop at count=2, DEPTH=4 ----
        cyc(); a_s_valid = 1'b1; a_s_data = 32'h30;
        cyc(); a_s_data = 32'h31;
        cyc(); a_s_data = 32'h32; a_m_ready = 1'b1;
        @(negedge clk);
        chk("pp_count_a", a_count,  2);
        chk("pp_md_a",    a_m_data, 32'h30);
        cyc(); a_s_data = 32'h33;
        @(negedge clk);
        chk("pp_count_b", a_count,  2);
        chk("pp_md_b",    a_m_data, 32'h31);
        cyc(); a_s_valid = 1'b0;
        @(negedge clk);
        chk("pp_count_c", a_count,  2);
        chk("pp_md_c",    a_m_data, 32'h32);
        cyc();
        @(negedge clk);
        chk("pp_md_d", a_m_data, 32'h33);
        cyc(); a_m_ready = 1'b0;
        @(negedge clk);
        chk("pp_count_end", a_count, 0);

        // ---- DEPTH=3: push/pop at count=2 across several wraps ----
        cyc(); b_s_valid = 1'b1; b_s_data = 32'h40;
        cyc(); b_s_data = 32'h41;
        for (int k = 0; k < 6; k++) begin
            cyc(); b_s_data = 32'h42 + k; b_m_ready = 1'b1;
            @(negedge clk);
            chk("d3_count", b_count,  2);
            chk("d3_md",    b_m_data, 32'h40 + k);
        end
        cyc(); b_s_valid = 1'b0;
        @(negedge clk);
        chk("d3_tail0", b_m_data, 32'h46);
        cyc();
        @(negedge clk);
        chk("d3_tail1", b_m_data, 32'h47);
        cyc(); b_m_ready = 1'b0;
        @(negedge clk);
        chk("d3_count_end", b_count, 0);

        // ---- flush priority ----
        cyc(); a_s_valid = 1'b1; a_s_data = 32'h50;
        cyc(); a_s_data = 32'h51;
        cyc(); a_s_data = 32'h52;
        cyc();
        a_flush = 1'b1; a_s_data = 32'h55; a_m_ready = 1'b1;
        @(negedge clk);
        chk("flush_s_ready", a_s_ready, 0);
        chk("flush_mv",      a_m_valid, 0);
        cyc();
        a_flush = 1'b0; a_s_valid = 1'b0; a_m_ready = 1'b0;
        @(negedge clk);
        chk("flush_count", a_count,   0);
        chk("flush_mv0",   a_m_valid, 0);
        chk("flush_md0",   a_m_data,  0);
        cyc(); a_s_valid = 1'b1; a_s_data = 32'h66;
        cyc(); a_s_valid = 1'b0; a_m_ready = 1'b1;
        @(negedge clk);
        chk("flush_next_count", a_count,  1);
        chk("flush_next_md",    a_m_data, 32'h66);
        cyc(); a_m_ready = 1'b0;
        @(negedge clk);
        chk("flush_next_empty", a_count, 0);

        // ---- async reset mid-burst ----
        cyc(); a_s_valid = 1'b1; a_s_data = 32'h70;
        cyc(); a_s_data = 32'h71;
        cyc(); a_s_valid = 1'b0;
        @(negedge clk);
        chk("arst_pre_count", a_count, 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_mv",      a_m_valid, 0);
        chk("arst_md",      a_m_data,  0);
        chk("arst_s_ready", a_s_ready, 0);
        chk("arst_count",   a_count,   0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("arst_post_count",   a_count,   0);
        chk("arst_post_s_ready", a_s_ready, 1);
        chk("arst_post_mv",      a_m_valid, 0);

        // ---- empty buffer, both sides ready ----
        cyc();
        a_s_valid = 1'b1; a_s_data = 32'h77; a_m_ready = 1'b1;
        @(negedge clk);
        chk("byp_s_ready", a_s_ready, 1);
`ifdef STAGE_FIFO_BYPASS_EN
        chk("byp_mv", a_m_valid, 1);
        chk("byp_md", a_m_data,  32'h77);
        cyc(); a_s_valid = 1'b0;
        @(negedge clk);
        chk("byp_count", a_count,   0);
        chk("byp_mv0",   a_m_valid, 0);
`else
        chk("byp_mv", a_m_valid, 0);
        chk("byp_md", a_m_data,  0);
        cyc(); a_s_valid = 1'b0;
        @(negedge clk);
        chk("byp_count", a_count,  1);
        chk("byp_md1",   a_m_data, 32'h77);
        cyc();
        @(negedge clk);
        chk("byp_count0", a_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed no end expected end");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stage_fifo.md
Name: stage_fifo

Overview:
- Parametrised valid/ready pipeline stage buffer; successor to the fixed single-entry inter-stage bus registers between the IF, ID, EX, MEM and WB stages of npc.
- Holds up to DEPTH payloads of WIDTH bits, so an upstream stage can keep issuing while downstream stalls, e.g. on multi-cycle LSU or IFU memory responses.
- Adds a synchronous flush for branch/ecall/mret redirect, which the current stage buses lack.

Parameters:
- WIDTH, 32: payload width in bits; must be at least 1.
- DEPTH, 2: number of entries; must be at least 1; need not be a power of two.
- CW, $clog2(DEPTH+1): width of the count output; derived, never overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- flush  input  1  synchronous clear of all held entries.
- s_valid  input  1  upstream offers s_data.
- s_ready  output  1  buffer can accept this cycle.
- s_data  input  WIDTH  upstream payload.
- m_valid  output  1  head entry is valid.
- m_ready  input  1  downstream consumes the head this cycle.
- m_data  output  WIDTH  head payload.
- count  output  CW  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset:
  - Asynchronous, active-high: wr_ptr=0, rd_ptr=0, count=0.
  - While rst=1: m_valid=0, s_ready=0, m_data=0.
  - Storage array is not reset.
- Push and pop:
  - push = s_valid & s_ready; pop = m_valid & m_ready.
- Ready and valid:
  - s_ready = ~rst & ~flush & (count != DEPTH).
  - s_ready depends only on registered state, flush and rst. There is no combinational path from m_ready to s_ready.
  - m_valid = ~rst & ~flush & (count != 0).
- Head data:
  - m_data = mem[rd_ptr] when m_valid=1, otherwise all-zero.
  - Latency: a payload pushed at edge N is visible on m_data/m_valid after edge N and can be popped at edge N+1 at the earliest (1-cycle latency).
- Ordering and stalls:
  - Strict FIFO order.
  - m_data and m_valid hold stable while m_valid=1 and m_ready=0.
- Pointers:
  - Advance by 1 on their event.
  - Wrap from DEPTH-1 to 0 by explicit compare, not by modulo-2^n.
- count:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. This is legal whenever 0 < count < DEPTH.
  - Full: s_ready=0, so a push cannot occur; pop is allowed.
  - Empty: m_valid=0, so a pop cannot occur; push is allowed.
- Flush:
  - At the edge where flush=1: wr_ptr=0, rd_ptr=0, count=0.
  - Any s_data offered that cycle is dropped; s_ready=0 already signals non-acceptance.
  - flush has priority over push and pop.
  - Normal operation resumes the cycle after flush deasserts.
- DEPTH=1:
  - Behaves as a full/empty register slice.
  - Throughput is one transfer per 2 cycles, because s_ready is not driven by m_ready.
- Reset mid-operation:
  - Contents are discarded immediately, without waiting for a clock edge.
  - After deassert: count=0, s_ready=1 from the first cycle.
- Invariant: count equals (pushes - pops) since the last reset/flush and never exceeds DEPTH.

Optional Feature:
- Macro: STAGE_FIFO_BYPASS_EN.
- When defined, and count=0 with s_valid=1, m_ready=1 and flush=0:
  - The payload passes combinationally: m_valid=1, m_data=s_data.
  - The transfer counts as both push and pop; storage, pointers and count are unchanged.
  - s_ready stays 1 in this case.
  - This gives 0-cycle latency through an empty buffer, at the cost of a combinational s_valid-to-m_valid path.
  - In all other cases, behaviour is identical to the non-bypass build.
- When undefined: no combinational input-to-output path; minimum latency is 1 cycle.

Test Plan:
- Reset/basic: hold rst 3 cycles, then push 0xA5A5_0001 with m_ready=1 → count 0→1→0, m_data=0xA5A5_0001 one cycle after push; s_ready=0 during rst.
- Fill and stall (DEPTH=4): m_ready=0, push 0x10,0x11,0x12,0x13 → count=4, s_ready=0; a fifth offer of 0x14 is not accepted; m_data holds 0x10.
- Drain order and wrap: from the full state, m_ready=1 while pushing 0x20..0x27 continuously → output sequence is 0x10..0x13 then 0x20..0x27; pointers wrap at least twice with no loss or duplication.
- Simultaneous push/pop at count=2 → count stays 2 and order is preserved. Repeat with DEPTH=3 to exercise the non-power-of-two wrap.
- Flush priority: count=3, assert flush together with s_valid=1 (data 0x55) and m_ready=1 → next cycle count=0, m_valid=0, 0x55 never appears on the output. Then push 0x66 → next output is 0x66.
- Async reset mid-burst: assert rst between clock edges with count=2 → m_valid=0 immediately; after release count=0. With STAGE_FIFO_BYPASS_EN on an empty buffer with m_ready=1, s_data=0x77 → m_data=0x77 in the same cycle and count stays 0.
